game_pace_controller: RTL and testbench
=======================================

Name: game_pace_controller

Overview:
- Game-level sequencer that sits directly upstream of the per-column state machines.
- Owns the game state: idle, playing or over.
- Generates the row-drop tick that paces letter falls, and issues a one-cycle column clear when a new game starts.
- Consumes the per-column correct and game_over flags to keep a 4-digit BCD score and a difficulty level that shortens the drop period.

Parameters:
- NUM_COLS, 3: number of column state machines monitored.
- BASE_PERIOD, 50000000: clock cycles per drop tick at level 0.
- PERIOD_STEP, 4000000: cycles removed from the period per level.
- MIN_PERIOD, 10000000: floor on the drop period.
- POINTS_PER_LEVEL, 10: correct answers needed per level increment.
- CNT_W, 26: width of the tick counter; must hold BASE_PERIOD-1.

Ports:
- clock, input, 1: system clock (CLOCK_50).
- reset_signal, input, 1: synchronous, active-high reset.
- start, input, 1: level input from a button; only its rising edge is used.
- correct, input, NUM_COLS: per-column correct flags; only rising edges are used.
- col_game_over, input, NUM_COLS: per-column game_over levels.
- drop_tick, output, 1: one-cycle pulse meaning "advance every column one row".
- clear_cols, output, 1: one-cycle pulse that resets all columns.
- playing, output, 1: high while in PLAYING.
- game_over, output, 1: high while in OVER.
- score_bcd, output, 16: four BCD digits, digit 3 most significant.
- level, output, 4: current difficulty level, 0..15.

Behaviour:
- Reset (synchronous, reset_signal high at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0: score_bcd=0, level=0, drop_tick=0, clear_cols=0, playing=0, game_over=0.
  - Tick counter, level-points counter and the edge-detect history registers for start and correct all clear to 0.
  - Reset overrides every other event in the same cycle.
- Edge detection:
  - start_rise = start & ~start_q.
  - corr_rise[i] = correct[i] & ~correct_q[i].
  - History registers update every cycle in every state.
  - A start held high through reset release therefore produces one rise.
- States:
  - IDLE: on start_rise, go to PLAYING. In that same cycle, pulse clear_cols=1 and clear score, level, level-points and tick counter.
  - PLAYING: if any bit of col_game_over is high, go to OVER. That cycle is game-over priority: no drop_tick and no score update from corr_rise.
  - PLAYING, otherwise: run the tick and score logic below.
  - OVER: score and level frozen, drop_tick held at 0. On start_rise, go to PLAYING with the same clearing and clear_cols pulse as from IDLE.
- playing and game_over are registered decodes of the state, so each is high exactly one cycle after the transition edge.
- Drop period:
  - period = max(BASE_PERIOD - level*PERIOD_STEP, MIN_PERIOD).
  - Compute at CNT_W+4 bits with no underflow.
- Tick counter, in PLAYING only:
  - If counter >= period-1: drop_tick=1 for one cycle and counter goes to 0.
  - Otherwise counter increments.
  - The >= compare keeps things safe when the period shrinks mid-count: the tick fires on the next cycle.
  - The first tick after a start occurs period cycles after entering PLAYING.
  - In IDLE and OVER, counter = 0 and drop_tick = 0.
- Score, in PLAYING only:
  - n = popcount(corr_rise), range 0..NUM_COLS. Simultaneous rises each count.
  - score_bcd += n as a BCD add with a per-digit carry, done in one cycle.
  - Saturates at 9999; never wraps.
- Level:
  - If lvl_pts + n >= POINTS_PER_LEVEL: lvl_pts = lvl_pts + n - POINTS_PER_LEVEL and level += 1, saturating at 15.
  - Otherwise lvl_pts += n.
  - lvl_pts keeps accumulating after level 15.
- Output timing: drop_tick and clear_cols are registered pulses, exactly 1 cycle wide.

Test Plan (bench parameters: BASE_PERIOD=20, PERIOD_STEP=4, MIN_PERIOD=8, POINTS_PER_LEVEL=3, NUM_COLS=3):
- Start and pacing: reset, then pulse start 1 cycle -> clear_cols high for exactly 1 cycle, playing=1 on the next cycle, drop_tick pulses every 20 cycles with the first pulse 20 cycles after entry; no ticks while IDLE.
- Simultaneous correct edges: raise correct=3'b101 in one cycle -> score_bcd=0x0002. Raise correct[1] -> score_bcd=0x0003, level=1, period becomes 16. Held-high correct adds nothing further.
- Level clamp: drive 12 correct edges -> level=4, tick spacing 8 (clamped at MIN_PERIOD, not 4).
- BCD carry and saturation: start from score 0x0009 plus 1 -> 0x0010. Force the score to 0x9998 via 3 edges in one cycle -> 0x9999, and it stays 0x9999 afterwards.
- Game over: assert col_game_over[2] together with a correct[0] rise -> game_over=1 next cycle, score unchanged, drop_tick stays 0. A start rise then yields clear_cols, score 0, level 0, playing=1.
- Reset mid-game: assert reset_signal while PLAYING at level 2, in the same cycle as a due tick -> no drop_tick, all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/game_pace_controller.sv
// Game-level sequencer: owns the IDLE/PLAYING/OVER game state, paces row
// drops with a level-dependent tick, pulses a column clear on game start,
// and keeps a saturating 4-digit BCD score plus a 0..15 difficulty level.
module game_pace_controller #(
    parameter int NUM_COLS         = 3,
    parameter int BASE_PERIOD      = 50000000,
    parameter int PERIOD_STEP      = 4000000,
    parameter int MIN_PERIOD       = 10000000,
    parameter int POINTS_PER_LEVEL = 10,
    parameter int CNT_W            = 26
) (
    input  logic                clock,
    input  logic                reset_signal,
    input  logic                start,
    input  logic [NUM_COLS-1:0] correct,
    input  logic [NUM_COLS-1:0] col_game_over,
    output logic                drop_tick,
    output logic                clear_cols,
    output logic                playing,
    output logic                game_over,
    output logic [15:0]         score_bcd,
    output logic [3:0]          level
);

    localparam int PW    = CNT_W + 4;
    localparam int NW    = $clog2(NUM_COLS + 1);
    localparam int PTS_W = $clog2(POINTS_PER_LEVEL + NUM_COLS + 1);

    localparam logic [PW-1:0]    BASE_P = PW'(BASE_PERIOD);
    localparam logic [PW-1:0]    STEP_P = PW'(PERIOD_STEP);
    localparam logic [PW-1:0]    MIN_P  = PW'(MIN_PERIOD);
    localparam logic [PTS_W-1:0] PPL_P  = PTS_W'(POINTS_PER_LEVEL);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_OVER    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                start_q, start_d;
    logic [NUM_COLS-1:0] correct_q, correct_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTS_W-1:0]    lvl_pts_q, lvl_pts_d;
    logic [15:0]         score_q, score_d;
    logic [3:0]          level_q, level_d;
    logic                drop_tick_q, drop_tick_d;
    logic                clear_cols_q, clear_cols_d;
    logic                playing_q, playing_d;
    logic                game_over_q, game_over_d;

    logic                start_rise;
    logic [NUM_COLS-1:0] corr_rise;
    logic [NW-1:0]       n_rise;
    logic [PW-1:0]       lvl_step;
    logic [PW-1:0]       period;
    logic                tick_due;
    logic [15:0]         score_add;
    logic [PTS_W-1:0]    pts_sum;

    assign start_rise = start & ~start_q;
    assign corr_rise  = correct & ~correct_q;

    // Count simultaneous correct rises; each column scores independently.
    always_comb begin
        n_rise = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            n_rise = n_rise + NW'(corr_rise[i]);
        end
    end

    // Drop period shrinks per level down to a floor; compare first so the
    // subtraction can never underflow.
    always_comb begin
        lvl_step = PW'(level_q) * STEP_P;
        if (lvl_step + MIN_P >= BASE_P) begin
            period = MIN_P;
        end else begin
            period = BASE_P - lvl_step;
        end
        // >= lets a count that overshot a freshly shortened period fire at once.
        tick_due = ({4'b0, cnt_q} >= period - PW'(1));
    end

    // Ripple the rise count through the four BCD digits; a carry out of the
    // top digit means the score would exceed 9999, so it pins there.
    always_comb begin
        logic [7:0] carry;
        logic [7:0] dsum;
        carry     = 8'(n_rise);
        dsum      = '0;
        score_add = '0;
        for (int d = 0; d < 4; d++) begin
            dsum                 = {4'b0, score_q[4*d +: 4]} + carry;
            score_add[4*d +: 4]  = 4'(dsum % 8'd10);
            carry                = dsum / 8'd10;
        end
        if (carry != 8'd0) begin
            score_add = 16'h9999;
        end
        pts_sum = lvl_pts_q + PTS_W'(n_rise);
    end

    // Next-state logic for the game state, tick counter, score and level.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lvl_pts_d    = lvl_pts_q;
        score_d      = score_q;
        level_d      = level_q;
        drop_tick_d  = 1'b0;
        clear_cols_d = 1'b0;
        start_d      = start;
        correct_d    = correct;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                cnt_d = '0;
                if (start_rise) begin
                    state_d      = ST_PLAYING;
                    clear_cols_d = 1'b1;
                    score_d      = '0;
                    level_d      = '0;
                    lvl_pts_d    = '0;
                end
            end
            ST_PLAYING: begin
                if (|col_game_over) begin
                    // Game over wins this cycle: no tick, no scoring.
                    state_d = ST_OVER;
                    cnt_d   = '0;
                end else begin
                    if (tick_due) begin
                        drop_tick_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    score_d = score_add;
                    if (pts_sum >= PPL_P) begin
                        lvl_pts_d = pts_sum - PPL_P;
                        if (level_q != 4'd15) begin
                            level_d = level_q + 4'd1;
                        end
                    end else begin
                        lvl_pts_d = pts_sum;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        playing_d   = (state_d == ST_PLAYING);
        game_over_d = (state_d == ST_OVER);
    end

    // Single register bank; reset takes precedence over every event.
    always_ff @(posedge clock) begin
        if (reset_signal) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            correct_q    <= '0;
            cnt_q        <= '0;
            lvl_pts_q    <= '0;
            score_q      <= '0;
            level_q      <= '0;
            drop_tick_q  <= 1'b0;
            clear_cols_q <= 1'b0;
            playing_q    <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            correct_q    <= correct_d;
            cnt_q        <= cnt_d;
            lvl_pts_q    <= lvl_pts_d;
            score_q      <= score_d;
            level_q      <= level_d;
            drop_tick_q  <= drop_tick_d;
            clear_cols_q <= clear_cols_d;
            playing_q    <= playing_d;
            game_over_q  <= game_over_d;
        end
    end

    assign drop_tick  = drop_tick_q;
    assign clear_cols = clear_cols_q;
    assign playing    = playing_q;
    assign game_over  = game_over_q;
    assign score_bcd  = score_q;
    assign level      = level_q;

endmodule

// File: tb/tb_game_pace_controller.sv
// Directed bench for game_pace_controller with a short drop period so that
// pacing, scoring, level clamp, saturation, game over and reset all fit.
module tb_game_pace_controller;

    logic        clock = 1'b0;
    logic        reset_signal;
    logic        start;
    logic [2:0]  correct;
    logic [2:0]  col_game_over;
    logic        drop_tick;
    logic        clear_cols;
    logic        playing;
    logic        game_over;
    logic [15:0] score_bcd;
    logic [3:0]  level;

    int vectors     = 0;
    int miscompares = 0;

    game_pace_controller #(
        .NUM_COLS         (3),
        .BASE_PERIOD      (20),
        .PERIOD_STEP      (4),
        .MIN_PERIOD       (8),
        .POINTS_PER_LEVEL (3),
        .CNT_W            (8)
    ) dut (
        .clock         (clock),
        .reset_signal  (reset_signal),
        .start         (start),
        .correct       (correct),
        .col_game_over (col_game_over),
        .drop_tick     (drop_tick),
        .clear_cols    (clear_cols),
        .playing       (playing),
        .game_over     (game_over),
        .score_bcd     (score_bcd),
        .level         (level)
    );

    // Clock generation
    always #5 clock = ~clock;

    // Advance one clock, then sample/drive 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One low cycle then one cycle with the given pattern: v's bits rise.
    task automatic pulse_corr(input logic [2:0] v);
        correct = 3'b000;
        step();
        correct = v;
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tick"},  {31'b0, drop_tick},  32'd0);
        chk({tag, "_clr"},   {31'b0, clear_cols}, 32'd0);
        chk({tag, "_play"},  {31'b0, playing},    32'd0);
        chk({tag, "_over"},  {31'b0, game_over},  32'd0);
        chk({tag, "_score"}, {16'b0, score_bcd},  32'd0);
        chk({tag, "_level"}, {28'b0, level},      32'd0);
    endtask

    initial begin
        reset_signal  = 1'b1;
        start         = 1'b0;
        correct       = 3'b000;
        col_game_over = 3'b000;
        #1;
        step();
        step();
        chk_all_zero("reset");

        // IDLE: nothing happens without a start edge.
        reset_signal = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("idle_tick", {31'b0, drop_tick}, 32'd0);
            chk("idle_play", {31'b0, playing},   32'd0);
        end

        // Start: entry edge E0.
        start = 1'b1;
        step();
        chk("start_clr",   {31'b0, clear_cols}, 32'd1);
        chk("start_play",  {31'b0, playing},    32'd1);
        chk("start_score", {16'b0, score_bcd},  32'd0);
        start = 1'b0;
        step(); // E1
        chk("clr_width", {31'b0, clear_cols}, 32'd0);
        chk("play_hold", {31'b0, playing},    32'd1);
        for (int e = 2; e <= 40; e++) begin
            step();
            chk("tick_p20", {31'b0, drop_tick}, {31'b0, (e == 20 || e == 40)});
        end

        // Two simultaneous rises.
        correct = 3'b101;
        step(); // E41
        chk("simul_score", {16'b0, score_bcd}, 32'h0002);
        chk("simul_level", {28'b0, level},     32'd0);
        correct = 3'b111;
        step(); // E42
        chk("lvl1_score", {16'b0, score_bcd}, 32'h0003);
        chk("lvl1_level", {28'b0, level},     32'd1);
        // Held-high inputs add nothing; period is now 16.
        for (int e = 43; e <= 72; e++) begin
            step();
            chk("tick_p16",  {31'b0, drop_tick}, {31'b0, (e == 56 || e == 72)});
            chk("held_score", {16'b0, score_bcd}, 32'h0003);
        end

        // Nine more rises (twelve total) -> level 4, period clamped at 8.
        pulse_corr(3'b111); // E73,E74
        pulse_corr(3'b111); // E75,E76
        chk("bcd9_score", {16'b0, score_bcd}, 32'h0009);
        pulse_corr(3'b111); // E77,E78
        chk("l4_score", {16'b0, score_bcd}, 32'h0012);
        chk("l4_level", {28'b0, level},     32'd4);
        for (int e = 79; e <= 96; e++) begin
            step();
            chk("tick_p8", {31'b0, drop_tick}, {31'b0, (e == 80 || e == 88 || e == 96)});
        end

        // Game over arrives together with a correct[0] rise.
        correct = 3'b000;
        step(); // E97
        correct       = 3'b001;
        col_game_over = 3'b100;
        step(); // E98
        chk("go_over",  {31'b0, game_over}, 32'd1);
        chk("go_play",  {31'b0, playing},   32'd0);
        chk("go_score", {16'b0, score_bcd}, 32'h0012);
        chk("go_tick",  {31'b0, drop_tick}, 32'd0);
        col_game_over = 3'b000;
        pulse_corr(3'b011);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("over_tick", {31'b0, drop_tick}, 32'd0);
        end
        chk("over_score", {16'b0, score_bcd}, 32'h0012);
        chk("over_level", {28'b0, level},     32'd4);
        chk("over_hold",  {31'b0, game_over}, 32'd1);

        // Restart from OVER.
        start = 1'b1;
        step();
        chk("rs_clr",   {31'b0, clear_cols}, 32'd1);
        chk("rs_play",  {31'b0, playing},    32'd1);
        chk("rs_over",  {31'b0, game_over},  32'd0);
        chk("rs_score", {16'b0, score_bcd},  32'd0);
        chk("rs_level", {28'b0, level},      32'd0);
        start = 1'b0;

        // BCD carry 9 -> 10.
        pulse_corr(3'b111);
        pulse_corr(3'b111);
        pulse_corr(3'b111);
        chk("c9_score", {16'b0, score_bcd}, 32'h0009);
        pulse_corr(3'b001);
        chk("c10_score", {16'b0, score_bcd}, 32'h0010);
        chk("c10_level", {28'b0, level},     32'd3);

        // Climb to 9998: 10 + 1 + 3*3329.
        pulse_corr(3'b001);
        for (int k = 0; k < 3329; k++) begin
            pulse_corr(3'b111);
        end
        chk("s9998_score", {16'b0, score_bcd}, 32'h9998);
        chk("s9998_level", {28'b0, level},     32'd15);
        pulse_corr(3'b111);
        chk("sat_score", {16'b0, score_bcd}, 32'h9999);
        pulse_corr(3'b111);
        chk("sat_hold", {16'b0, score_bcd}, 32'h9999);
        chk("sat_level", {28'b0, level},    32'd15);

        // End this game, start a new one and reach level 2.
        col_game_over = 3'b001;
        step();
        col_game_over = 3'b000;
        step();
        start = 1'b1;
        step(); // F0
        chk("g3_clr", {31'b0, clear_cols}, 32'd1);
        start = 1'b0;
        pulse_corr(3'b111); // F1,F2
        pulse_corr(3'b111); // F3,F4
        chk("g3_level", {28'b0, level},     32'd2);
        chk("g3_score", {16'b0, score_bcd}, 32'h0006);
        for (int f = 5; f <= 11; f++) begin
            step();
            chk("g3_tick", {31'b0, drop_tick}, 32'd0);
        end

        // Reset exactly on the edge where the level-2 tick is due (F12).
        reset_signal = 1'b1;
        step();
        chk_all_zero("midrst");
        reset_signal = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step();
            chk("post_tick", {31'b0, drop_tick}, 32'd0);
            chk("post_play", {31'b0, playing},   32'd0);
        end
        chk("post_score", {16'b0, score_bcd}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
